// File: rtl/benes_cfg_arbiter.sv
// Four-way round-robin arbiter that owns the Benes switch-configuration load port.
// A grant is held for a whole burst and released on the last beat or on a starvation timeout.
module benes_cfg_arbiter #(
    parameter int unsigned CFG_W    = 32,
    parameter int unsigned MAX_IDLE = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [3:0]         req,
    input  logic [3:0]         s_valid,
    input  logic [4*CFG_W-1:0] s_data,
    input  logic [3:0]         s_last,
    output logic [3:0]         s_ready,
    output logic [3:0]         gnt,
    output logic [1:0]         gnt_id,
    output logic               busy,
    output logic               m_valid,
    output logic [CFG_W-1:0]   m_data,
    output logic               m_last,
    input  logic               m_ready,
    output logic               abort
);

    localparam int unsigned N_SRC = 4;
    localparam int unsigned CNT_W = 8;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_BUSY    = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;

    logic [1:0]       state, state_d;
    logic [3:0]       gnt_d;
    logic [1:0]       gnt_id_d;
    logic             busy_d;
    logic             abort_d;
    logic [1:0]       ptr, ptr_d;
    logic [CNT_W-1:0] idle_cnt, idle_cnt_d;

    logic [1:0]       cand;
    logic [1:0]       pick;
    logic             pick_vld;
    logic             sel_valid;
    logic             hs;

    // Rotating priority search starting at ptr
    always_comb begin
        cand     = '0;
        pick     = '0;
        pick_vld = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            cand = ptr + 2'(i);
            if (!pick_vld && req[cand]) begin
                pick     = cand;
                pick_vld = 1'b1;
            end
        end
    end

    // Zero-latency datapath mux, gated by the registered grant
    always_comb begin
        m_data = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (gnt_id == 2'(i)) begin
                m_data = s_data[i*CFG_W +: CFG_W];
            end
        end
    end

    assign sel_valid = s_valid[gnt_id];
    assign m_valid   = busy & sel_valid;
    assign m_last    = busy & s_last[gnt_id];
    assign s_ready   = gnt & {N_SRC{m_ready}};
    assign hs        = m_valid & m_ready;

    always_comb begin
        state_d    = state;
        gnt_d      = gnt;
        gnt_id_d   = gnt_id;
        busy_d     = busy;
        abort_d    = 1'b0;
        ptr_d      = ptr;
        idle_cnt_d = idle_cnt;
        case (state)
            ST_IDLE: begin
                if (pick_vld) begin
                    state_d    = ST_BUSY;
                    gnt_d      = 4'(1) << pick;
                    gnt_id_d   = pick;
                    busy_d     = 1'b1;
                    idle_cnt_d = '0;
                end
            end
            ST_BUSY: begin
                // A completing handshake always wins over an expiring counter
                if (hs && m_last) begin
                    state_d = ST_RELEASE;
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                end else if (sel_valid) begin
                    idle_cnt_d = '0;
                end else if (idle_cnt + CNT_W'(1) == CNT_W'(MAX_IDLE)) begin
                    state_d = ST_RELEASE;
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                    abort_d = 1'b1;
                end else begin
                    idle_cnt_d = idle_cnt + CNT_W'(1);
                end
            end
            ST_RELEASE: begin
                state_d    = ST_IDLE;
                ptr_d      = gnt_id + 2'd1;
                idle_cnt_d = '0;
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            gnt      <= '0;
            gnt_id   <= '0;
            busy     <= 1'b0;
            abort    <= 1'b0;
            ptr      <= '0;
            idle_cnt <= '0;
        end else begin
            state    <= state_d;
            gnt      <= gnt_d;
            gnt_id   <= gnt_id_d;
            busy     <= busy_d;
            abort    <= abort_d;
            ptr      <= ptr_d;
            idle_cnt <= idle_cnt_d;
        end
    end

endmodule

// File: tb/tb_benes_cfg_arbiter.sv
// Bench for benes_cfg_arbiter: directed scenarios plus random traffic, all checked
// cycle by cycle against a burst-level reference model.
module tb_benes_cfg_arbiter;

    localparam int unsigned CFG_W    = 32;
    localparam int unsigned MAX_IDLE = 16;

    logic               clk = 1'b0;
    logic               rst;
    logic [3:0]         req;
    logic [3:0]         s_valid;
    logic [4*CFG_W-1:0] s_data;
    logic [3:0]         s_last;
    logic [3:0]         s_ready;
    logic [3:0]         gnt;
    logic [1:0]         gnt_id;
    logic               busy;
    logic               m_valid;
    logic [CFG_W-1:0]   m_data;
    logic               m_last;
    logic               m_ready;
    logic               abort;

    benes_cfg_arbiter #(.CFG_W(CFG_W), .MAX_IDLE(MAX_IDLE)) dut (
        .clk(clk), .rst(rst), .req(req), .s_valid(s_valid), .s_data(s_data),
        .s_last(s_last), .s_ready(s_ready), .gnt(gnt), .gnt_id(gnt_id), .busy(busy),
        .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
        .abort(abort)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference model: who owns the port, release cooldown, pointer, starvation count
    int o_own, o_rel, o_ptr, o_idle, o_abort;
    logic [3:0] hs_src;

    // Source behaviour: beats remaining, start-of-burst stall, current word
    int rem [4];
    bit stall [4];
    logic [CFG_W-1:0] word [4];
    bit rnd_mode = 0;

    int dut_order[$];
    int dut_start[$];
    bit prev_busy = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        o_own = -1; o_rel = 0; o_ptr = 0; o_idle = 0; o_abort = 0; hs_src = '0;
    endtask

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            s_valid[i] = (rem[i] > 0) && !stall[i];
            s_last[i]  = (rem[i] == 1);
            req[i]     = (rem[i] > 0);
            s_data[i*CFG_W +: CFG_W] = word[i];
        end
    endtask

    task automatic check_outputs();
        logic [3:0] eg, er;
        logic ev, el;
        logic [CFG_W-1:0] ed;
        eg = '0; er = '0; ev = 1'b0; el = 1'b0; ed = '0;
        if (o_own >= 0) begin
            eg[o_own] = 1'b1;
            er[o_own] = m_ready;
            ev = s_valid[o_own];
            el = s_last[o_own];
            ed = word[o_own];
        end
        chk("gnt", 64'(gnt), 64'(eg));
        chk("busy", 64'(busy), 64'(o_own >= 0));
        chk("abort", 64'(abort), 64'(o_abort));
        chk("m_valid", 64'(m_valid), 64'(ev));
        chk("m_last", 64'(m_last), 64'(el));
        chk("s_ready", 64'(s_ready), 64'(er));
        if (o_own >= 0) begin
            chk("gnt_id", 64'(gnt_id), 64'(o_own));
            chk("m_data", 64'(m_data), 64'(ed));
        end
        if (busy && !prev_busy) begin
            dut_order.push_back(int'(gnt_id));
            dut_start.push_back(cyc);
        end
        prev_busy = busy;
    endtask

    task automatic model_step();
        int k, c;
        hs_src = '0;
        if (o_own >= 0) begin
            k = o_own;
            if (s_valid[k] && m_ready) hs_src[k] = 1'b1;
            if (s_valid[k] && m_ready && s_last[k]) begin
                o_own = -1; o_rel = 1; o_abort = 0; o_ptr = (k + 1) % 4; o_idle = 0;
            end else if (s_valid[k]) begin
                o_idle = 0;
            end else begin
                o_idle++;
                if (o_idle == MAX_IDLE) begin
                    o_own = -1; o_rel = 1; o_abort = 1; o_ptr = (k + 1) % 4; o_idle = 0;
                end
            end
        end else if (o_rel != 0) begin
            o_rel = 0; o_abort = 0;
        end else if (req != 4'b0) begin
            for (int j = 0; j < 4; j++) begin
                c = (o_ptr + j) % 4;
                if (o_own < 0 && req[c]) begin
                    o_own = c; o_idle = 0;
                end
            end
        end
    endtask

    task automatic post_edge();
        for (int i = 0; i < 4; i++) begin
            if (hs_src[i]) begin
                rem[i]--;
                word[i] = $urandom;
            end
        end
        if (rnd_mode) begin
            m_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < 4; i++) begin
                if (stall[i] && $urandom_range(0, 23) == 0) stall[i] = 0;
                if (rem[i] == 0 && $urandom_range(0, 7) == 0) begin
                    rem[i]   = $urandom_range(1, 4);
                    stall[i] = ($urandom_range(0, 2) == 0);
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        cyc++;
        if (rst) model_reset(); else model_step();
        #1;
        post_edge();
        drive();
    endtask

    function automatic bit all_done();
        bit d = (o_own < 0) && (o_rel == 0);
        for (int i = 0; i < 4; i++) if (rem[i] != 0) d = 0;
        return d;
    endfunction

    task automatic run_drain(input string tag, input int budget);
        int n = 0;
        while (!all_done() && n < budget) begin
            tick();
            n++;
        end
        chk(tag, 64'(all_done()), 64'(1));
    endtask

    initial begin
        rst = 1'b1; m_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rem[i] = 0; stall[i] = 0; word[i] = $urandom;
        end
        model_reset();
        drive();
        tick();
        chk("reset_gnt_id", 64'(gnt_id), 64'(0));
        rst = 1'b0;

        // Fairness with everyone requesting, then wrap back to source 0
        for (int i = 0; i < 4; i++) rem[i] = 1;
        drive();
        run_drain("drain_fair", 40);
        rem[0] = 1; drive();
        run_drain("drain_fair0", 20);
        if (dut_order.size() == 5) begin
            for (int i = 0; i < 5; i++) chk("fair_order", 64'(dut_order[i]), 64'(i % 4));
            for (int i = 1; i < 5; i++) chk("fair_gap", 64'(dut_start[i] - dut_start[i-1]), 64'(3));
        end else begin
            chk("fair_count", 64'(dut_order.size()), 64'(5));
        end

        // Pointer wrap: ptr=1 serves 3 before 0, then ptr=0 serves 0 before 3
        dut_order.delete();
        rem[0] = 1; rem[3] = 1; drive();
        run_drain("drain_wrap1", 30);
        rem[3] = 1; drive();
        run_drain("drain_wrap2", 20);
        rem[0] = 1; rem[3] = 1; drive();
        run_drain("drain_wrap3", 30);
        chk("wrap_count", 64'(dut_order.size()), 64'(5));
        if (dut_order.size() == 5) begin
            chk("wrap_a", 64'(dut_order[0]), 64'(3));
            chk("wrap_b", 64'(dut_order[1]), 64'(0));
            chk("wrap_c", 64'(dut_order[3]), 64'(0));
            chk("wrap_d", 64'(dut_order[4]), 64'(3));
        end

        // Single requester, 3-beat burst
        rem[0] = 3; drive();
        run_drain("drain_single", 20);

        // Backpressure well beyond MAX_IDLE must not abort
        rem[1] = 1; m_ready = 1'b0; drive();
        repeat (42) tick();
        m_ready = 1'b1;
        run_drain("drain_bp", 20);

        // Starvation timeout on source 2, source 3 waiting
        rem[2] = 2; stall[2] = 1; rem[3] = 1; drive();
        repeat (20) tick();
        stall[2] = 0; drive();
        run_drain("drain_timeout", 40);

        // Reset mid-burst: source 2 loses its burst, pointer returns to 0
        rem[1] = 1; drive();
        run_drain("drain_pre_rst", 20);
        rem[2] = 4; drive();
        for (int n = 0; n < 20 && rem[2] > 2; n++) tick();
        chk("rst_beats", 64'(rem[2]), 64'(2));
        rem[1] = 1; drive();
        rst = 1'b1;
        #1;
        chk("rst_gnt", 64'(gnt), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_m_valid", 64'(m_valid), 64'(0));
        chk("rst_s_ready", 64'(s_ready), 64'(0));
        rem[2] = 0; model_reset(); drive();
        prev_busy = 0;
        dut_order.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        run_drain("drain_post_rst", 20);
        chk("rst_next_grant", 64'(dut_order.size() > 0 ? dut_order[0] : 99), 64'(1));

        // Random traffic with random backpressure and starvation
        rnd_mode = 1;
        repeat (500) tick();
        rnd_mode = 0;
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) stall[i] = 0;
        drive();
        run_drain("drain_random", 200);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
